mem_port: RTL and testbench

Synthesizable memory port that sits directly downstream of the ALU and serves its load/store requests over the readReq/writeReq and readAck/writeAck handshake. It holds a byte-addressed RAM and transfers 32-bit little-endian words at any byte address. It replaces the behavioural RAM model used on the ALU bench, so the same ALU runs unchanged against synthesizable memory.

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_port_byte_ram.sv | 35 +++
 rtl/mem_port.sv | 124 ++++++++++++
 tb/tb_mem_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the mem_port memory port and its byte RAM.
package mem_port_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int BYTE_LANES = 4;
    localparam int BYTE_WIDTH = WORD_WIDTH / BYTE_LANES;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        READ,
        WRITE
    } accessKind_t;

endpackage

// File: rtl/mem_port_byte_ram.sv
// Byte-wide RAM with four combinational read lanes and four synchronous write
// lanes; every lane carries its own byte index so unaligned words need no muxing.
module byte_ram
    import mem_port_pkg::*;
#(
    parameter int RAMSIZE = 2048,
    localparam int IDXW = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1
) (
    input  logic                                 clk,
    input  logic [BYTE_LANES-1:0][IDXW-1:0]       rdIdx,
    output logic [BYTE_LANES-1:0][BYTE_WIDTH-1:0] rdData,
    input  logic                                 wrEn,
    input  logic [BYTE_LANES-1:0][IDXW-1:0]       wrIdx,
    input  logic [BYTE_LANES-1:0][BYTE_WIDTH-1:0] wrData
);

    logic [BYTE_WIDTH-1:0] mem [RAMSIZE];

    always_comb begin
        for (int k = 0; k < BYTE_LANES; k++) begin
            rdData[k] = mem[rdIdx[k]];
        end
    end

    // NOTE: the array has no reset branch; clearing it would turn the RAM into
    // thousands of resettable flops instead of a memory macro.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < BYTE_LANES; k++) begin
                mem[wrIdx[k]] <= wrData[k];
            end
        end
    end

endmodule

// File: rtl/mem_port.sv
// Load/store memory port for the ALU: IDLE/ACCESS/DONE handshake over a byte RAM,
// little-endian 32-bit words at any byte address. Define MEM_PORT_BOUNDS_EN to add fault.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int RAMSIZE = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] ramAddress,
    input  logic [WORD_WIDTH-1:0] ramOut,
    input  logic                  readReq,
    input  logic                  writeReq,
    output logic [WORD_WIDTH-1:0] ramValue,
    output logic                  readAck,
    output logic                  writeAck
`ifdef MEM_PORT_BOUNDS_EN
    ,
    output logic                  fault
`endif
);

    localparam int IDXW = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;

    state_t                               state;
    state_t                               stateNext;
    accessKind_t                          reqKind;
    logic [WORD_WIDTH-1:0]                reqAddress;
    logic [WORD_WIDTH-1:0]                reqData;
    logic [BYTE_LANES-1:0][IDXW-1:0]       byteIdx;
    logic [BYTE_LANES-1:0][BYTE_WIDTH-1:0] rdBytes;
    logic                                 outOfRange;
    logic                                 wrEn;

    // Each lane wraps independently, so a word straddling the top of memory
    // continues at byte 0.
    always_comb begin
        for (int k = 0; k < BYTE_LANES; k++) begin
            byteIdx[k] = IDXW'((reqAddress + WORD_WIDTH'(k)) % WORD_WIDTH'(RAMSIZE));
        end
    end

`ifdef MEM_PORT_BOUNDS_EN
    assign outOfRange = ({1'b0, reqAddress} + 33'd3) >= 33'(RAMSIZE);
`else
    assign outOfRange = 1'b0;
`endif

    // Reset in ACCESS must drop a pending write, hence the reset term here.
    assign wrEn = (state == ACCESS) && (reqKind == WRITE) && !outOfRange && !reset;

    byte_ram #(
        .RAMSIZE(RAMSIZE)
    ) u_byteRam (
        .clk   (clk),
        .rdIdx (byteIdx),
        .rdData(rdBytes),
        .wrEn  (wrEn),
        .wrIdx (byteIdx),
        .wrData(reqData)
    );

    always_comb begin
        // NOTE: defaulting stateNext before the case keeps every path assigned,
        // so no latch is inferred.
        stateNext = state;
        case (state)
            IDLE:    if (readReq || writeReq) stateNext = ACCESS;
            ACCESS:  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            reqKind    <= READ;
            reqAddress <= '0;
            reqData    <= '0;
            ramValue   <= '0;
            readAck    <= 1'b0;
            writeAck   <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (readReq || writeReq) begin
                        reqAddress <= ramAddress;
                        reqKind    <= writeReq ? WRITE : READ;
                        if (writeReq) reqData <= ramOut;
                    end
                end
                ACCESS: begin
                    if (reqKind == READ) ramValue <= outOfRange ? '0 : rdBytes;
                    readAck  <= (reqKind == READ);
                    writeAck <= (reqKind == WRITE);
                end
                DONE: begin
                    readAck  <= 1'b0;
                    writeAck <= 1'b0;
                end
                default: begin
                    readAck  <= 1'b0;
                    writeAck <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_PORT_BOUNDS_EN
    // fault is only ever high alongside the ack pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else begin
            fault <= (state == ACCESS) && outOfRange;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases plus randomized traffic checked
// against a byte-array reference model. Honors MEM_PORT_BOUNDS_EN when defined.
module tb_mem_port;

    localparam int RAMSIZE = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramValue;
    logic        readAck;
    logic        writeAck;
`ifdef MEM_PORT_BOUNDS_EN
    logic        fault;
`endif

    always #5 clk = ~clk;

    mem_port #(
        .RAMSIZE(RAMSIZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ramAddress(ramAddress),
        .ramOut    (ramOut),
        .readReq   (readReq),
        .writeReq  (writeReq),
        .ramValue  (ramValue),
        .readAck   (readAck),
        .writeAck  (writeAck)
`ifdef MEM_PORT_BOUNDS_EN
        ,
        .fault     (fault)
`endif
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [7:0]  modelMem [RAMSIZE];
    logic [31:0] lastRead;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned byteAt(input logic [31:0] addr, input int k);
        logic [31:0] a;
        a = addr + 32'(k);
        return a % 32'(RAMSIZE);
    endfunction

    function automatic bit isOob(input logic [31:0] addr);
`ifdef MEM_PORT_BOUNDS_EN
        return (64'(addr) + 64'd3) >= 64'(RAMSIZE);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = modelMem[byteAt(addr, k)];
        return r;
    endfunction

    // One complete handshake; checks ack latency, pulse width and data against the model.
    task automatic doAccess(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int          lat;
        bit          seen;
        bit          oob;
        logic [31:0] expVal;
        oob        = isOob(addr);
        ramAddress = addr;
        ramOut     = data;
        readReq    = rd;
        writeReq   = wr;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 6) begin
            cycle();
            lat++;
            if (readAck || writeAck) seen = 1'b1;
        end
        readReq  = 1'b0;
        writeReq = 1'b0;
        check("ack_latency", 32'(lat), 32'd2);
        check("readAck", {31'b0, readAck}, {31'b0, !wr});
        check("writeAck", {31'b0, writeAck}, {31'b0, wr});
`ifdef MEM_PORT_BOUNDS_EN
        check("fault_with_ack", {31'b0, fault}, {31'b0, oob});
`endif
        if (!wr) begin
            expVal = oob ? 32'h0 : modelRead(addr);
            check("read_data", ramValue, expVal);
            lastRead = expVal;
        end else begin
            check("value_held_on_write", ramValue, lastRead);
            if (!oob) begin
                for (int k = 0; k < 4; k++) modelMem[byteAt(addr, k)] = data[8*k +: 8];
            end
        end
        cycle();
        check("ack_pulse_end", {30'b0, readAck, writeAck}, 32'd0);
`ifdef MEM_PORT_BOUNDS_EN
        check("fault_clear", {31'b0, fault}, 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  expBytes [4];
        logic [7:0]  wrapBytes [4];
        logic [31:0] word;
        logic [31:0] addr;
        int          sel;

        reset      = 1'b1;
        readReq    = 1'b0;
        writeReq   = 1'b0;
        ramAddress = '0;
        ramOut     = '0;
        lastRead   = '0;
        cycle();
        cycle();
        check("reset_ramValue", ramValue, 32'h0);
        check("reset_acks", {30'b0, readAck, writeAck}, 32'd0);
`ifdef MEM_PORT_BOUNDS_EN
        check("reset_fault", {31'b0, fault}, 32'd0);
`endif
        reset = 1'b0;
        cycle();

        // Fill the whole RAM so every later read has a defined expectation.
        for (int a = 0; a < RAMSIZE; a += 4) doAccess(1'b1, 1'b0, 32'(a), $urandom);

        // Aligned write then read, byte placement checked lane by lane.
        doAccess(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        doAccess(1'b0, 1'b1, 32'h10, 32'h0);
        check("aligned_read", ramValue, 32'hDEADBEEF);
        expBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int k = 0; k < 4; k++) begin
            doAccess(1'b0, 1'b1, 32'h10 + 32'(k), 32'h0);
            check("byte_lane", {24'b0, ramValue[7:0]}, {24'b0, expBytes[k]});
        end

        // Unaligned read picking up a preloaded byte at 0x14.
        word = modelRead(32'h14);
        doAccess(1'b1, 1'b0, 32'h14, {word[31:8], 8'h55});
        doAccess(1'b0, 1'b1, 32'h11, 32'h0);
        check("unaligned_read", ramValue, 32'h55DEADBE);

        // Both requests high: write wins, no readAck.
        doAccess(1'b1, 1'b1, 32'h20, 32'h12345678);
        doAccess(1'b0, 1'b1, 32'h20, 32'h0);
        check("write_wins", ramValue, 32'h12345678);

        // Write straddling the top of memory.
        doAccess(1'b1, 1'b0, 32'(RAMSIZE - 2), 32'hA1B2C3D4);
`ifdef MEM_PORT_BOUNDS_EN
        doAccess(1'b0, 1'b1, 32'(RAMSIZE - 4), 32'h0);
        doAccess(1'b0, 1'b1, 32'h0, 32'h0);
        doAccess(1'b0, 1'b1, 32'(RAMSIZE - 2), 32'h0);
        check("oob_read_zero", ramValue, 32'h0);
`else
        wrapBytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            doAccess(1'b0, 1'b1, 32'(byteAt(32'(RAMSIZE - 2), k)), 32'h0);
            check("wrap_byte", {24'b0, ramValue[7:0]}, {24'b0, wrapBytes[k]});
        end
`endif

        // Reset during ACCESS of a write: no ack, memory untouched.
        ramAddress = 32'h40;
        ramOut     = 32'hFFFFFFFF;
        writeReq   = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        check("midreset_acks", {30'b0, readAck, writeAck}, 32'd0);
        check("midreset_ramValue", ramValue, 32'h0);
        reset    = 1'b0;
        writeReq = 1'b0;
        lastRead = 32'h0;
        cycle();
        check("midreset_idle_acks", {30'b0, readAck, writeAck}, 32'd0);
        doAccess(1'b0, 1'b1, 32'h40, 32'h0);

        // Held read request: one access every three cycles.
        ramAddress = 32'h10;
        readReq    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("held_readAck", {31'b0, readAck}, {31'b0, (i % 3) == 2});
            check("held_writeAck", {31'b0, writeAck}, 32'd0);
            if ((i % 3) == 2) check("held_data", ramValue, modelRead(32'h10));
        end
        readReq  = 1'b0;
        lastRead = modelRead(32'h10);
        cycle();
        check("held_release", {31'b0, readAck}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, RAMSIZE - 1));
            sel = int'($urandom_range(0, 2));
            doAccess(sel != 0, sel != 1, addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
